// File: rtl/jcs_serial_subtractor_if.sv
// Stream interface for jcs_serial_subtractor: operand side (valid/ready,
// a, b, borrow_in) and result side (valid/ready, diff, borrow_out,
// skip_count). The overflow signal exists only when JCS_OVF_EN is defined.
interface jcs_serial_subtractor_if #(
   parameter int WIDTH = 16
);
   localparam int NB = WIDTH / 4;
   localparam int CW = $clog2(NB + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic [CW-1:0]    skip_count;
`ifdef JCS_OVF_EN
   logic             overflow;

   modport master (
      output in_valid, a, b, borrow_in, out_ready,
      input  in_ready, out_valid, diff, borrow_out, skip_count, overflow
   );
   modport slave (
      input  in_valid, a, b, borrow_in, out_ready,
      output in_ready, out_valid, diff, borrow_out, skip_count, overflow
   );
`else
   modport master (
      output in_valid, a, b, borrow_in, out_ready,
      input  in_ready, out_valid, diff, borrow_out, skip_count
   );
   modport slave (
      input  in_valid, a, b, borrow_in, out_ready,
      output in_ready, out_valid, diff, borrow_out, skip_count
   );
`endif
endinterface

// File: rtl/jcs_serial_subtractor.sv
// Block-serial subtractor: diff = a - b - borrow_in, one 4-bit carry-skip
// block per clock, computed as a + ~b + ~borrow_in. Counts blocks whose
// carry bypassed the ripple chain. Optional signed overflow output is
// enabled by defining JCS_OVF_EN.
module jcs_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   jcs_serial_subtractor_if.slave bus
);
   localparam int NB = WIDTH / 4;
   localparam int CW = $clog2(NB + 1);
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] diff_reg;
   logic             c_reg;
   logic [IW-1:0]    idx_reg;
   logic [CW-1:0]    skip_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;
   logic             borrow_reg;

   // Datapath for the block currently selected by idx_reg
   logic [3:0] blk_a;
   logic [3:0] blk_bn;
   logic [3:0] blk_p;
   logic [3:0] blk_sum;
   logic [4:0] blk_c;
   logic       blk_skip;
   logic       c_next;

   assign blk_a    = a_reg[idx_reg*4 +: 4];
   assign blk_bn   = ~b_reg[idx_reg*4 +: 4];
   assign blk_c[0] = c_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bit
         assign blk_p[gi]     = blk_a[gi] ^ blk_bn[gi];
         assign blk_sum[gi]   = blk_p[gi] ^ blk_c[gi];
         assign blk_c[gi + 1] = (blk_a[gi] & blk_bn[gi]) |
                                (blk_a[gi] & blk_c[gi])  |
                                (blk_bn[gi] & blk_c[gi]);
      end
   endgenerate

   // All-propagate block: the entry carry passes straight through
   assign blk_skip = &blk_p;
   assign c_next   = blk_skip ? c_reg : blk_c[4];

`ifdef JCS_OVF_EN
   logic ovf_reg;
   logic ovf_next;

   // The last block holds the MSB, so blk_sum[3] is the final sign bit
   assign ovf_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &
                     (blk_sum[3] != a_reg[WIDTH-1]);
   assign bus.overflow = ovf_reg;
`endif

   assign bus.in_ready   = in_ready_reg;
   assign bus.out_valid  = out_valid_reg;
   assign bus.diff       = diff_reg;
   assign bus.borrow_out = borrow_reg;
   assign bus.skip_count = skip_reg;

   // Control FSM plus per-block datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         diff_reg      <= '0;
         c_reg         <= 1'b0;
         idx_reg       <= '0;
         skip_reg      <= '0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         borrow_reg    <= 1'b0;
`ifdef JCS_OVF_EN
         ovf_reg       <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               in_ready_reg <= 1'b1;
               if (in_ready_reg && bus.in_valid) begin
                  a_reg        <= bus.a;
                  b_reg        <= bus.b;
                  c_reg        <= ~bus.borrow_in;
                  idx_reg      <= '0;
                  skip_reg     <= '0;
                  diff_reg     <= '0;
                  borrow_reg   <= 1'b0;
`ifdef JCS_OVF_EN
                  ovf_reg      <= 1'b0;
`endif
                  in_ready_reg <= 1'b0;
                  state_reg    <= RUN;
               end
            end
            RUN: begin
               diff_reg[idx_reg*4 +: 4] <= blk_sum;
               c_reg                    <= c_next;
               if (blk_skip) begin
                  skip_reg <= skip_reg + CW'(1);
               end
               if (idx_reg == IW'(NB - 1)) begin
                  borrow_reg    <= ~c_next;
`ifdef JCS_OVF_EN
                  ovf_reg       <= ovf_next;
`endif
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  idx_reg <= idx_reg + IW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_jcs_serial_subtractor.sv
// Self-checking bench for jcs_serial_subtractor (WIDTH=16). Expected values
// come from plain integer arithmetic on the operands. Define JCS_OVF_EN to
// also exercise the overflow output.
module tb_jcs_serial_subtractor;
   localparam int W  = 16;
   localparam int NB = 4;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   jcs_serial_subtractor_if #(.WIDTH(W)) bus ();

   jcs_serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: unsigned difference, underflow flag, equal-nibble count,
   // signed range check
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbi, output logic [W-1:0] d,
                                 output logic bo, output logic [CW-1:0] sk,
                                 output logic ov);
      int r;
      int sr;
      int n;
      logic [31:0] ru;
      r  = int'(ma) - int'(mb) - int'(mbi);
      ru = r;
      d  = ru[W-1:0];
      bo = (r < 0);
      n  = 0;
      for (int i = 0; i < NB; i++) begin
         if (ma[4*i +: 4] == mb[4*i +: 4]) n++;
      end
      sk = CW'(n);
      sr = int'($signed(ma)) - int'($signed(mb)) - int'(mbi);
      ov = (sr > 32767) || (sr < -32768);
   endfunction

   // Drives one operation through accept and result handshake; lat=-1 when
   // in_ready never came, lat=50 when out_valid never came.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbi, output logic [W-1:0] d,
                         output logic bo, output logic [CW-1:0] sk,
                         output logic ov, output int lat);
      int n;
      n = 0;
      d = '0; bo = 1'b0; sk = '0; ov = 1'b0; lat = -1;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) return;
      bus.a = ta; bus.b = tb_; bus.borrow_in = tbi; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.borrow_in = ~tbi;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      d = bus.diff; bo = bus.borrow_out; sk = bus.skip_count;
`ifdef JCS_OVF_EN
      ov = bus.overflow;
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.diff !== '0 ||
          bus.borrow_out !== 1'b0 || bus.skip_count !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b diff=%h bo=%b sk=%0d, want all 0",
                  bus.in_ready, bus.out_valid, bus.diff, bus.borrow_out, bus.skip_count);
      end
`ifdef JCS_OVF_EN
      total++;
      if (bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_overflow: got %b want 0", bus.overflow);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
      end
      $display("reset: in_ready=%b after release", bus.in_ready);
   endtask

   task automatic test_directed();
      logic [W-1:0] va [5];
      logic [W-1:0] vb [5];
      logic         vbi [5];
      logic [W-1:0] vd [5];
      logic         vbo [5];
      logic [W-1:0] d, ed;
      logic bo, ebo, ov, eov;
      logic [CW-1:0] sk, esk;
      int lat;
      va[0] = 16'h1234; vb[0] = 16'h0234; vbi[0] = 1'b0; vd[0] = 16'h1000; vbo[0] = 1'b0;
      va[1] = 16'h0000; vb[1] = 16'h0001; vbi[1] = 1'b0; vd[1] = 16'hFFFF; vbo[1] = 1'b1;
      va[2] = 16'h0000; vb[2] = 16'h0000; vbi[2] = 1'b1; vd[2] = 16'hFFFF; vbo[2] = 1'b1;
      va[3] = 16'h0000; vb[3] = 16'h0000; vbi[3] = 1'b0; vd[3] = 16'h0000; vbo[3] = 1'b0;
      va[4] = 16'hFFFF; vb[4] = 16'hFFFF; vbi[4] = 1'b1; vd[4] = 16'hFFFF; vbo[4] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         model(va[i], vb[i], vbi[i], ed, ebo, esk, eov);
         run_op(va[i], vb[i], vbi[i], d, bo, sk, ov, lat);
         total++;
         if (lat != NB) begin
            bad++;
            $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, NB);
         end
         total++;
         if (d !== vd[i] || bo !== vbo[i] || sk !== esk) begin
            bad++;
            $display("FAIL directed%0d_result: got diff=%h bo=%b sk=%0d want diff=%h bo=%b sk=%0d",
                     i, d, bo, sk, vd[i], vbo[i], esk);
         end
         $display("directed: a=%h b=%h bi=%b -> diff=%h bo=%b sk=%0d lat=%0d",
                  va[i], vb[i], vbi[i], d, bo, sk, lat);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ta, tb_, d, ed;
      logic tbi, bo, ebo, ov, eov;
      logic [CW-1:0] sk, esk;
      logic [3:0] mask;
      int lat;
      for (int i = 0; i < 40; i++) begin
         ta = W'($urandom); tb_ = W'($urandom); tbi = 1'($urandom);
         mask = 4'($urandom);
         for (int k = 0; k < NB; k++) begin
            if (mask[k]) tb_[4*k +: 4] = ta[4*k +: 4];
         end
         model(ta, tb_, tbi, ed, ebo, esk, eov);
         run_op(ta, tb_, tbi, d, bo, sk, ov, lat);
         total++;
         if (lat != NB || d !== ed || bo !== ebo || sk !== esk) begin
            bad++;
            $display("FAIL random%0d: got diff=%h bo=%b sk=%0d lat=%0d want diff=%h bo=%b sk=%0d lat=%0d",
                     i, d, bo, sk, lat, ed, ebo, esk, NB);
         end
`ifdef JCS_OVF_EN
         total++;
         if (ov !== eov) begin
            bad++;
            $display("FAIL random%0d_overflow: got %b want %b", i, ov, eov);
         end
`endif
         $display("random: a=%h b=%h bi=%b -> diff=%h bo=%b sk=%0d", ta, tb_, tbi, d, bo, sk);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] d1, d2, ed1, ed2;
      logic bo1, bo2, ov1, ov2;
      logic [CW-1:0] sk1, sk2;
      int n;
      model(16'h4321, 16'h1234, 1'b0, ed1, bo1, sk1, ov1);
      model(16'h0F0F, 16'h1F00, 1'b1, ed2, bo2, sk2, ov2);
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      bus.a = 16'h4321; bus.b = 16'h1234; bus.borrow_in = 1'b0; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      total++;
      if (n != NB) begin
         bad++;
         $display("FAIL bp_first_latency: got %0d want %0d", n, NB);
      end
      bus.a = 16'h0F0F; bus.b = 16'h1F00; bus.borrow_in = 1'b1; bus.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         d1 = bus.diff;
         total++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || d1 !== ed1 ||
             bus.borrow_out !== bo1 || bus.skip_count !== sk1) begin
            bad++;
            $display("FAIL bp_hold%0d: got vld=%b rdy=%b diff=%h bo=%b sk=%0d want vld=1 rdy=0 diff=%h bo=%b sk=%0d",
                     c, bus.out_valid, bus.in_ready, d1, bus.borrow_out, bus.skip_count, ed1, bo1, sk1);
         end
         $display("backpressure: cycle %0d diff=%h vld=%b rdy=%b", c, d1, bus.out_valid, bus.in_ready);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_after_handshake: got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_second_accept: got rdy=%b want 0", bus.in_ready);
      end
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      d2 = bus.diff;
      total++;
      if (n != NB || d2 !== ed2 || bus.borrow_out !== bo2 || bus.skip_count !== sk2) begin
         bad++;
         $display("FAIL bp_second_result: got diff=%h bo=%b sk=%0d lat=%0d want diff=%h bo=%b sk=%0d lat=%0d",
                  d2, bus.borrow_out, bus.skip_count, n, ed2, bo2, sk2, NB);
      end
      $display("backpressure: second op diff=%h", d2);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] d, ed;
      logic bo, ebo, ov, eov;
      logic [CW-1:0] sk, esk;
      int n, lat;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      bus.a = 16'hABCD; bus.b = 16'h1111; bus.borrow_in = 1'b0; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.diff !== '0 ||
          bus.borrow_out !== 1'b0 || bus.skip_count !== '0) begin
         bad++;
         $display("FAIL midrun_reset: got rdy=%b vld=%b diff=%h bo=%b sk=%0d want all 0",
                  bus.in_ready, bus.out_valid, bus.diff, bus.borrow_out, bus.skip_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL midrun_release: got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
      end
      model(16'h5A5A, 16'h5AA5, 1'b1, ed, ebo, esk, eov);
      run_op(16'h5A5A, 16'h5AA5, 1'b1, d, bo, sk, ov, lat);
      total++;
      if (lat != NB || d !== ed || bo !== ebo || sk !== esk) begin
         bad++;
         $display("FAIL midrun_next_op: got diff=%h bo=%b sk=%0d lat=%0d want diff=%h bo=%b sk=%0d",
                  d, bo, sk, lat, ed, ebo, esk);
      end
      $display("reset mid-run: next op diff=%h bo=%b sk=%0d", d, bo, sk);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] qd [$];
      logic         qb [$];
      logic [CW-1:0] qs [$];
      logic [W-1:0] ed, ta, tb_;
      logic ebo, eov, tbi;
      logic [CW-1:0] esk;
      int last, got, cyc;
      last = -1; got = 0; cyc = 0;
      bus.out_ready = 1'b1;
      while (got < 4 && cyc < 200) begin
         if (bus.out_valid === 1'b1) begin
            total++;
            if (qd.size() == 0) begin
               bad++;
               $display("FAIL b2b_unexpected: got diff=%h with no op pending", bus.diff);
            end else if (bus.diff !== qd[0] || bus.borrow_out !== qb[0] || bus.skip_count !== qs[0]) begin
               bad++;
               $display("FAIL b2b_result%0d: got diff=%h bo=%b sk=%0d want diff=%h bo=%b sk=%0d",
                        got, bus.diff, bus.borrow_out, bus.skip_count, qd[0], qb[0], qs[0]);
            end
            if (qd.size() != 0) begin
               void'(qd.pop_front()); void'(qb.pop_front()); void'(qs.pop_front());
            end
            if (last >= 0) begin
               total++;
               if (cyc - last != NB + 2) begin
                  bad++;
                  $display("FAIL b2b_period: got %0d cycles want %0d", cyc - last, NB + 2);
               end
            end
            $display("back_to_back: result %0d diff=%h at cycle %0d", got, bus.diff, cyc);
            last = cyc;
            got++;
         end
         if (bus.in_ready === 1'b1 && got < 4) begin
            ta = W'($urandom); tb_ = W'($urandom); tbi = 1'($urandom);
            model(ta, tb_, tbi, ed, ebo, esk, eov);
            qd.push_back(ed); qb.push_back(ebo); qs.push_back(esk);
            bus.a = ta; bus.b = tb_; bus.borrow_in = tbi; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      total++;
      if (got != 4) begin
         bad++;
         $display("FAIL b2b_timeout: got %0d results want 4", got);
      end
      @(negedge clk);
   endtask

`ifdef JCS_OVF_EN
   task automatic test_overflow();
      logic [W-1:0] d;
      logic bo, ov;
      logic [CW-1:0] sk;
      int lat;
      run_op(16'h8000, 16'h0001, 1'b0, d, bo, sk, ov, lat);
      total++;
      if (d !== 16'h7FFF || ov !== 1'b1) begin
         bad++;
         $display("FAIL ovf_set: got diff=%h ovf=%b want diff=7fff ovf=1", d, ov);
      end
      $display("overflow: 8000-0001 diff=%h ovf=%b", d, ov);
      run_op(16'h0005, 16'h0003, 1'b0, d, bo, sk, ov, lat);
      total++;
      if (d !== 16'h0002 || ov !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear: got diff=%h ovf=%b want diff=0002 ovf=0", d, ov);
      end
      $display("overflow: 0005-0003 diff=%h ovf=%b", d, ov);
   endtask
`endif

   initial begin
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.borrow_in = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
`ifdef JCS_OVF_EN
      test_overflow();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/jcs_serial_subtractor.md
# jcs_serial_subtractor

Block-serial subtractor computing `diff = a - b - borrow_in` over `WIDTH` bits, one 4-bit carry-skip block per clock. It is the subtract-direction companion to the team's combinational carry-skip adder. It sits on a valid/ready stream between an operand producer and a result consumer. It reports how many blocks took the skip path, which feeds datapath-activity statistics.

## Interface
- `WIDTH`, default 16: operand width; must be a multiple of 4 and ≥ 8.
- `NB`: derived, `WIDTH/4`; the number of blocks.
- `CW`: derived, `$clog2(NB+1)`; the width of `skip_count`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand strobe.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: minuend.
- `b` in WIDTH: subtrahend.
- `borrow_in` in 1: incoming borrow.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `diff` out WIDTH: `a - b - borrow_in`, mod 2^WIDTH.
- `borrow_out` out 1: 1 when the unsigned result underflowed.
- `skip_count` out CW: number of blocks whose borrow bypassed the ripple.
- `overflow` out 1: signed overflow; present only with `JCS_OVF_EN`.

## Operation
- Arithmetic is two's complement: `a + ~b + ~borrow_in`.
- Internal carry register `c`. It is loaded with `~borrow_in` on accept.
- Per block i:
  - `p = a[i] ^ ~b[i]`.
  - Ripple carry out `r` = majority of `a`, `~b` and `c`, bit by bit.
  - `diff[4i+3:4i] = a ^ ~b ^ carries`.
  - Next `c` is the entry `c` when `&p` (skip), otherwise `r`.
- `skip_count` increments on every skip block.
- `borrow_out = ~c` after the last block.
- States:
  - IDLE: `in_ready=1`. On `in_valid`, latch `a`, `b` and `c`; clear `idx` and `skip_count`; go to RUN.
  - RUN: process block `idx`, then `idx++`. When `idx==NB-1` is processed, go to DONE.
  - DONE: `out_valid=1`. `diff`, `borrow_out`, `skip_count` and `overflow` are held stable. On `out_ready`, go to IDLE.
- `in_ready` is 0 in RUN and DONE. `in_valid` in those states is ignored and the operand is not consumed.
- Operands are captured at accept. Input changes during RUN have no effect.
- Reset:
  - All outputs are 0 (`in_ready` is 0 while `rst_n` is low, then 1 in IDLE).
  - `idx=0`, `c=0`, state is IDLE.
  - Reset asserted mid-RUN or mid-DONE aborts the operation with no partial result.
- `diff` bits for blocks not yet processed read 0 during RUN. Consumers must rely only on `out_valid`.

## Timing
- Accept on edge E0. Blocks are computed on edges E1..E_NB. `out_valid` rises after E_NB, so latency is NB cycles from accept to valid; 4 cycles at `WIDTH=16`.
- Result handshake completes on the edge where `out_valid & out_ready`. `in_ready` is 1 on the following cycle.
- Throughput is one operation per NB+2 cycles with `out_ready` held at 1.
- `out_ready` low holds DONE indefinitely. There is no timeout.

## Configuration
- `JCS_OVF_EN` defined:
  - Port `overflow` exists.
  - `overflow = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`, registered in DONE, 0 at reset.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16, `a=0x1234`, `b=0x0234`, `borrow_in=0` → after 4 cycles: `diff=0x1000`, `borrow_out=0`.
- `a=0x0000`, `b=0x0001`, `borrow_in=0` → `diff=0xFFFF`, `borrow_out=1`.
- Full skip: `a=0x0000`, `b=0x0000`, `borrow_in=1` → `diff=0xFFFF`, `borrow_out=1`, `skip_count=4`. Same operands with `borrow_in=0` → `diff=0x0000`, `borrow_out=0`, `skip_count=4`.
- Backpressure: hold `out_ready=0` for 3 cycles in DONE while driving a new `in_valid`.
  - Outputs stay stable and `in_ready` stays 0.
  - The second operand is accepted only after the handshake.
- Reset mid-RUN: drop `rst_n` after block 2. All outputs go to 0 immediately; `in_ready=1` after release; the next op computes correctly.
- With `JCS_OVF_EN`: `a=0x8000`, `b=0x0001` → `diff=0x7FFF`, `overflow=1`. With `a=0x0005`, `b=0x0003` → `overflow=0`.
